stream_arb_mux: RTL and testbench

Parametrised N-channel registered stream multiplexer with per-channel valid/ready handshake. It generalises the combinational 4:1 select mux into three selection modes: fixed select, fixed priority and round-robin. The output is a one-entry register with backpressure. It sits between multiple producer streams and a single consumer, such as an ALU operand or result path.

---
 rtl/stream_arb_mux.sv | 157 +++++++++++++++
 tb/tb_stream_arb_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   N-channel stream multiplexer with a one-entry registered output.
//   A grant is chosen combinationally from the current inputs in one of
//   three modes: fixed select, fixed priority (lowest index wins) or
//   round-robin. The granted word is captured into the output register.
//
// Handshake:
//   A word moves on any interface only in a cycle where its valid and
//   ready are both high at the rising edge of Clk. A producer keeps
//   valid and data stable until that happens. Ready may depend on valid.
//   The output register accepts a new word when it is empty or is being
//   drained in the same cycle.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset
//   InData    NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   InValid   per-channel valid
//   InReady   per-channel accept, at most one bit high per cycle
//   Mode      00 fixed select, 01 fixed priority, 10 round-robin,
//             11 reserved (never grants)
//   Sel       channel index used in fixed-select mode
//   OutData   registered output word
//   OutValid  OutData holds a word
//   OutReady  consumer takes OutData this cycle
//   OutChan   index of the channel that supplied OutData

module stream_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NCH*WIDTH-1:0]   InData,
    input  logic [NCH-1:0]         InValid,
    output logic [NCH-1:0]         InReady,
    input  logic [1:0]             Mode,
    input  logic [SELW-1:0]        Sel,
    output logic [WIDTH-1:0]       OutData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [SELW-1:0]        OutChan
);

    typedef enum logic [1:0] {
        MODE_SEL  = 2'b00,
        MODE_PRIO = 2'b01,
        MODE_RR   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    mode_e            mode;
    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic             transfer;

    // Round-robin pointer: last channel granted in round-robin mode.
    // The search for the next grant starts one past it.
    logic [SELW-1:0]  ptr;

    assign mode = mode_e'(Mode);
    assign load = !OutValid || OutReady;

    // Grant selection. Only valid channels are ever granted, so a grant
    // together with load is always a real transfer.
    always_comb begin
        logic [SELW:0]   rr_sum;
        logic [SELW-1:0] rr_idx;
        grant_valid = 1'b0;
        grant       = '0;
        rr_sum      = '0;
        rr_idx      = '0;
        case (mode)
            MODE_SEL: begin
                // Comparing Sel against every real index means Sel >= NCH
                // simply never matches.
                for (int i = 0; i < NCH; i++) begin
                    if (Sel == SELW'(i) && InValid[i]) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end
            MODE_PRIO: begin
                // Walk downward so the lowest valid index is written last.
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (InValid[i]) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end
            MODE_RR: begin
                // Candidates ptr+1 .. ptr+NCH modulo NCH. One extra bit in
                // rr_sum holds ptr+k before the wrap (max 2*NCH-1).
                for (int k = 1; k <= NCH; k++) begin
                    rr_sum = {1'b0, ptr} + (SELW+1)'(k);
                    if (rr_sum >= (SELW+1)'(NCH)) begin
                        rr_sum = rr_sum - (SELW+1)'(NCH);
                    end
                    rr_idx = rr_sum[SELW-1:0];
                    if (!grant_valid && InValid[rr_idx]) begin
                        grant_valid = 1'b1;
                        grant       = rr_idx;
                    end
                end
            end
            default: begin
                grant_valid = 1'b0;
            end
        endcase
    end

    // Data of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Nothing is accepted while in reset: a word taken then would be lost.
    assign transfer = !Rst && load && grant_valid;

    always_comb begin
        InReady = '0;
        for (int i = 0; i < NCH; i++) begin
            InReady[i] = transfer && (grant == SELW'(i));
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutValid <= 1'b0;
            OutData  <= '0;
            OutChan  <= '0;
            ptr      <= SELW'(NCH - 1);
        end else if (transfer) begin
            // Covers both loading an empty register and drain+reload.
            OutValid <= 1'b1;
            OutData  <= grant_data;
            OutChan  <= grant;
            if (mode == MODE_RR) begin
                ptr <= grant;
            end
        end else if (OutReady) begin
            // Drained with nothing to replace it; data/chan keep last values.
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT NCH=4 ----------------
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;

    stream_arb_mux #(.WIDTH(8), .NCH(4)) dut (
        .Clk(clk), .Rst(rst),
        .InData(in_data), .InValid(in_valid), .InReady(in_ready),
        .Mode(mode), .Sel(sel),
        .OutData(out_data), .OutValid(out_valid), .OutReady(out_ready),
        .OutChan(out_chan)
    );

    // ---------------- DUT NCH=3 ----------------
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_chan3;

    stream_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (
        .Clk(clk), .Rst(rst),
        .InData(in_data3), .InValid(in_valid3), .InReady(in_ready3),
        .Mode(mode3), .Sel(sel3),
        .OutData(out_data3), .OutValid(out_valid3), .OutReady(out_ready3),
        .OutChan(out_chan3)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] data4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] data3 [3] = '{8'hA1, 8'hB2, 8'hC3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops expected channels and checks one output word per cycle.
    task automatic drain_rr4(input int n);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            tick();
            c = exp_q.pop_front();
            check("rr4_valid", 32'(out_valid), 32'h1);
            check("rr4_chan", 32'(out_chan), 32'(c));
            check("rr4_data", 32'(out_data), 32'(data4[c[1:0]]));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        in_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid   = 4'hF;
        mode       = 2'b10;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = {8'hC3, 8'hB2, 8'hA1};
        in_valid3  = 3'b111;
        mode3      = 2'b00;
        sel3       = 2'd3;
        out_ready3 = 1'b1;

        // Reset held two cycles with inputs active
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_chan", 32'(out_chan), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);

        // First round-robin grant after reset goes to channel 0
        rst = 1'b0;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h1);
        tick();
        check("rr_first_valid", 32'(out_valid), 32'h1);
        check("rr_first_chan", 32'(out_chan), 32'h0);
        check("rr_first_data", 32'(out_data), 32'h11);

        // Fixed select Sel=2
        mode = 2'b00;
        sel  = 2'd2;
        #1;
        check("sel_ready", 32'(in_ready), 32'h4);
        tick();
        check("sel_data", 32'(out_data), 32'h33);
        check("sel_chan", 32'(out_chan), 32'h2);
        check("sel_valid", 32'(out_valid), 32'h1);

        // Selected channel not valid: no grant, output drains
        in_valid = 4'b1011;
        #1;
        check("sel_none_ready", 32'(in_ready), 32'h0);
        tick();
        check("sel_none_valid", 32'(out_valid), 32'h0);
        check("sel_none_data_hold", 32'(out_data), 32'h33);
        check("sel_none_chan_hold", 32'(out_chan), 32'h2);

        // Fixed priority
        mode     = 2'b01;
        in_valid = 4'b1010;
        #1;
        check("prio_ready_a", 32'(in_ready), 32'h2);
        tick();
        check("prio_data_a", 32'(out_data), 32'h22);
        check("prio_chan_a", 32'(out_chan), 32'h1);
        in_valid = 4'b1000;
        #1;
        check("prio_ready_b", 32'(in_ready), 32'h8);
        tick();
        check("prio_data_b", 32'(out_data), 32'h44);
        check("prio_chan_b", 32'(out_chan), 32'h3);

        // Reset while a word is held
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(in_ready), 32'h0);
        tick();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data", 32'(out_data), 32'h0);
        check("midrst_chan", 32'(out_chan), 32'h0);

        // Round-robin, all valid: 0,1,2,3,0,1,2,3
        mode     = 2'b10;
        in_valid = 4'hF;
        rst      = 1'b0;
        exp_q    = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
        drain_rr4(8);

        // Round-robin with channels 0 and 3 only: 0,3,0,3
        in_valid = 4'b1001;
        exp_q    = '{8'd0, 8'd3, 8'd0, 8'd3};
        drain_rr4(4);

        // Backpressure: holding channel 3 word (0x44)
        out_ready = 1'b0;
        in_valid  = 4'hF;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h55};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_data", 32'(out_data), 32'h44);
            check("bp_chan", 32'(out_chan), 32'h3);
        end

        // Release: drain and reload in the same edge (next RR is ch0)
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'h1);
        check("bp_release_data", 32'(out_data), 32'h55);
        check("bp_release_chan", 32'(out_chan), 32'h0);

        // Reserved mode never grants
        mode = 2'b11;
        #1;
        check("rsvd_ready", 32'(in_ready), 32'h0);
        tick();
        check("rsvd_valid", 32'(out_valid), 32'h0);
        check("rsvd_data_hold", 32'(out_data), 32'h55);

        // NCH=3: Sel=3 has been applied all along and never granted
        check("n3_sel3_ready", 32'(in_ready3), 32'h0);
        check("n3_sel3_valid", 32'(out_valid3), 32'h0);

        // NCH=3: Sel=2 grants channel 2
        sel3 = 2'd2;
        #1;
        check("n3_sel2_ready", 32'(in_ready3), 32'h4);
        tick();
        check("n3_sel2_chan", 32'(out_chan3), 32'h2);
        check("n3_sel2_data", 32'(out_data3), 32'hC3);

        // NCH=3 round-robin wraps 0,1,2,0 (pointer still at reset value 2)
        mode3 = 2'b10;
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd0};
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c;
            tick();
            c = exp_q.pop_front();
            check("n3_rr_chan", 32'(out_chan3), 32'(c));
            check("n3_rr_data", 32'(out_data3), 32'(data3[c[1:0]]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
